// File: rtl/mem_access_ctrl.sv
// Splits 16-bit load/store requests into sequential byte accesses on a byte-wide memory port.
// Latency accept->resp_valid: store byte 2, store word 3, load byte 3, load word 4 cycles.
// Backpressure: req_ready is low from accept until the response cycle ends; one request in flight.
// Optional feature: define ALIGN_CHECK_EN to reject odd-address word accesses with resp_err.
module mem_access_ctrl #(
    parameter int ADDR_W     = 16,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              resp_valid,
    output logic [15:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP, RESP} state_t;

    state_t            state;
    logic              wr_q;
    logic              byte_q;
    logic [ADDR_W-1:0] a1_q;
    logic [7:0]        wb1_q;
    logic [7:0]        rb0_q;

    // Byte order: byte 0 goes to A, byte 1 to A+1; a byte store always uses wdata[7:0]
    logic [7:0]        wb0;
    logic [7:0]        wb1;
    logic [ADDR_W-1:0] a1;
    logic [15:0]       word_rdata;
    logic              misaligned;

    assign wb0 = (req_byte || !BIG_ENDIAN) ? req_wdata[7:0] : req_wdata[15:8];
    assign wb1 = BIG_ENDIAN ? req_wdata[7:0] : req_wdata[15:8];
    assign a1  = req_addr + ADDR_W'(1);

    // In CAP, mem_rdata carries byte 1 and rb0_q holds byte 0
    assign word_rdata = BIG_ENDIAN ? {rb0_q, mem_rdata} : {mem_rdata, rb0_q};

`ifdef ALIGN_CHECK_EN
    assign misaligned = !req_byte && req_addr[0];

    // Error flag rides along with the single response pulse of a rejected word access
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_err <= 1'b0;
        end else if (state == IDLE && req_valid && misaligned) begin
            resp_err <= 1'b1;
        end else if (state == RESP) begin
            resp_err <= 1'b0;
        end
    end
`else
    assign misaligned = 1'b0;
    assign resp_err   = 1'b0;
`endif

    // Sequencer: outputs are registered, so each transition loads the strobes of the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 16'h0000;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'h00;
            wr_q       <= 1'b0;
            byte_q     <= 1'b0;
            a1_q       <= '0;
            wb1_q      <= 8'h00;
            rb0_q      <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        wr_q      <= req_write;
                        byte_q    <= req_byte;
                        a1_q      <= a1;
                        wb1_q     <= wb1;
                        if (misaligned) begin
                            // Rejected access: no memory traffic, straight to the response
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            mem_addr  <= req_addr;
                            mem_read  <= !req_write;
                            mem_write <= req_write;
                            if (req_write) begin
                                mem_wdata <= wb0;
                            end
                            state <= ACC0;
                        end
                    end
                end
                ACC0: begin
                    if (!byte_q) begin
                        mem_addr  <= a1_q;
                        mem_read  <= !wr_q;
                        mem_write <= wr_q;
                        if (wr_q) begin
                            mem_wdata <= wb1_q;
                        end
                        state <= ACC1;
                    end else begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (wr_q) begin
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            state <= CAP;
                        end
                    end
                end
                ACC1: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    if (wr_q) begin
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        // Byte 0 read data returns during the byte 1 strobe
                        rb0_q <= mem_rdata;
                        state <= CAP;
                    end
                end
                CAP: begin
                    resp_rdata <= byte_q ? {8'h00, mem_rdata} : word_rdata;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    mem_read   <= 1'b0;
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-wide memory model.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
// Memory contents for wrap tests are preloaded through the DUT's own store path.
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [0:65535];
    int rd_cnt  = 0;
    int wr_cnt  = 0;
    int overlap = 0;
    int rd0;
    int wr0;

    mem_access_ctrl #(.ADDR_W(16), .BIG_ENDIAN(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_byte   (req_byte),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory: writes commit at the strobe edge, read data appears the cycle after mem_read
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_read) begin
            mem_rdata <= mem[mem_addr];
            rd_cnt <= rd_cnt + 1;
        end
        if (mem_read && mem_write) begin
            overlap <= overlap + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns in cycle T+1 after the accept edge
    task automatic issue(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_byte  = b;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;

        // 1: reset held two cycles
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", 32'(req_ready), 'h1);
        check("rst_rd", 32'(mem_read), 'h0);
        check("rst_wr", 32'(mem_write), 'h0);
        check("rst_rdata", 32'(resp_rdata), 'h0000);
        check("rst_resp", 32'(resp_valid), 'h0);
        check("rst_err", 32'(resp_err), 'h0);
        check("rst_addr", 32'(mem_addr), 'h0000);
        tick();

        // 2: store word 0x0040 <- 0xBEDE
        issue(1'b1, 1'b0, 16'h0040, 16'hBEDE);
        check("sw_t1_wr", 32'(mem_write), 'h1);
        check("sw_t1_rd", 32'(mem_read), 'h0);
        check("sw_t1_addr", 32'(mem_addr), 'h0040);
        check("sw_t1_dat", 32'(mem_wdata), 'hBE);
        check("sw_t1_rdy", 32'(req_ready), 'h0);
        tick();
        check("sw_t2_wr", 32'(mem_write), 'h1);
        check("sw_t2_addr", 32'(mem_addr), 'h0041);
        check("sw_t2_dat", 32'(mem_wdata), 'hDE);
        check("sw_t2_resp", 32'(resp_valid), 'h0);
        tick();
        check("sw_t3_resp", 32'(resp_valid), 'h1);
        check("sw_t3_wr", 32'(mem_write), 'h0);
        check("sw_t3_rdata", 32'(resp_rdata), 'h0000);
        tick();
        check("sw_t4_resp", 32'(resp_valid), 'h0);
        check("sw_t4_rdy", 32'(req_ready), 'h1);
        check("sw_mem40", 32'(mem[16'h0040]), 'hBE);
        check("sw_mem41", 32'(mem[16'h0041]), 'hDE);

        // 3: load word 0x0040 -> 0xBEDE at T+4
        issue(1'b0, 1'b0, 16'h0040, 16'h0000);
        check("lw_t1_rd", 32'(mem_read), 'h1);
        check("lw_t1_addr", 32'(mem_addr), 'h0040);
        tick();
        check("lw_t2_rd", 32'(mem_read), 'h1);
        check("lw_t2_addr", 32'(mem_addr), 'h0041);
        tick();
        check("lw_t3_rd", 32'(mem_read), 'h0);
        check("lw_t3_resp", 32'(resp_valid), 'h0);
        tick();
        check("lw_t4_resp", 32'(resp_valid), 'h1);
        check("lw_t4_rdata", 32'(resp_rdata), 'hBEDE);
        check("lw_t4_err", 32'(resp_err), 'h0);
        tick();
        check("lw_t5_resp", 32'(resp_valid), 'h0);

        // 3: load byte 0x0041 -> 0x00DE at T+3 (odd byte address never flagged)
        issue(1'b0, 1'b1, 16'h0041, 16'h0000);
        check("lb_t1_rd", 32'(mem_read), 'h1);
        check("lb_t1_addr", 32'(mem_addr), 'h0041);
        tick();
        check("lb_t2_rd", 32'(mem_read), 'h0);
        check("lb_t2_resp", 32'(resp_valid), 'h0);
        tick();
        check("lb_t3_resp", 32'(resp_valid), 'h1);
        check("lb_t3_rdata", 32'(resp_rdata), 'h00DE);
        check("lb_t3_err", 32'(resp_err), 'h0);
        tick();

        // Store byte uses wdata[7:0]; response at T+2, read data untouched
        issue(1'b1, 1'b1, 16'h0050, 16'h1234);
        check("sb_t1_wr", 32'(mem_write), 'h1);
        check("sb_t1_addr", 32'(mem_addr), 'h0050);
        check("sb_t1_dat", 32'(mem_wdata), 'h34);
        tick();
        check("sb_t2_resp", 32'(resp_valid), 'h1);
        check("sb_t2_wr", 32'(mem_write), 'h0);
        check("sb_t2_rdata", 32'(resp_rdata), 'h00DE);
        tick();

        // 4: word access at 0xFFFF
`ifdef ALIGN_CHECK_EN
        rd0 = rd_cnt;
        issue(1'b0, 1'b0, 16'hFFFF, 16'h0000);
        check("mis_t1_resp", 32'(resp_valid), 'h1);
        check("mis_t1_err", 32'(resp_err), 'h1);
        check("mis_t1_rd", 32'(mem_read), 'h0);
        check("mis_t1_rdata", 32'(resp_rdata), 'h00DE);
        tick();
        check("mis_t2_resp", 32'(resp_valid), 'h0);
        check("mis_t2_err", 32'(resp_err), 'h0);
        check("mis_t2_rdy", 32'(req_ready), 'h1);
        check("mis_nord", 32'(rd_cnt - rd0), 'h0);
`else
        issue(1'b1, 1'b0, 16'hFFFF, 16'h1234);
        check("wrap_sw_t1_addr", 32'(mem_addr), 'hFFFF);
        check("wrap_sw_t1_dat", 32'(mem_wdata), 'h12);
        tick();
        check("wrap_sw_t2_addr", 32'(mem_addr), 'h0000);
        check("wrap_sw_t2_dat", 32'(mem_wdata), 'h34);
        tick();
        tick();
        issue(1'b0, 1'b0, 16'hFFFF, 16'h0000);
        check("wrap_lw_t1_addr", 32'(mem_addr), 'hFFFF);
        check("wrap_lw_t1_rd", 32'(mem_read), 'h1);
        tick();
        check("wrap_lw_t2_addr", 32'(mem_addr), 'h0000);
        check("wrap_lw_t2_rd", 32'(mem_read), 'h1);
        tick();
        tick();
        check("wrap_lw_t4_resp", 32'(resp_valid), 'h1);
        check("wrap_lw_t4_rdata", 32'(resp_rdata), 'h1234);
        check("wrap_lw_t4_err", 32'(resp_err), 'h0);
`endif
        tick();

        // 5: req_valid held through a word load -> one access pair only
        rd0 = rd_cnt;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 16'h0040;
        tick();
        check("hold_t1_rdy", 32'(req_ready), 'h0);
        tick();
        check("hold_t2_rdy", 32'(req_ready), 'h0);
        tick();
        check("hold_t3_rdy", 32'(req_ready), 'h0);
        tick();
        check("hold_t4_rdy", 32'(req_ready), 'h0);
        check("hold_t4_resp", 32'(resp_valid), 'h1);
        check("hold_t4_rdata", 32'(resp_rdata), 'hBEDE);
        tick();
        check("hold_t5_rdy", 32'(req_ready), 'h1);
        check("hold_reads", 32'(rd_cnt - rd0), 'h2);
        req_valid = 1'b0;
        tick();
        check("hold_t6_rd", 32'(mem_read), 'h0);
        check("hold_t6_rdy", 32'(req_ready), 'h1);

        // 6: reset lands on the edge that would launch byte 1 of a word store
        wr0 = wr_cnt;
        issue(1'b1, 1'b0, 16'h0060, 16'hA5C3);
        check("rs_t1_wr", 32'(mem_write), 'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rs_wr", 32'(mem_write), 'h0);
        check("rs_rd", 32'(mem_read), 'h0);
        check("rs_rdy", 32'(req_ready), 'h1);
        check("rs_resp0", 32'(resp_valid), 'h0);
        check("rs_rdata", 32'(resp_rdata), 'h0000);
        tick();
        check("rs_resp1", 32'(resp_valid), 'h0);
        check("rs_wr1", 32'(mem_write), 'h0);
        tick();
        check("rs_resp2", 32'(resp_valid), 'h0);
        check("rs_writes", 32'(wr_cnt - wr0), 'h1);
        check("rs_mem60", 32'(mem[16'h0060]), 'hA5);

        check("no_overlap", 32'(overlap), 'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
